// File: rtl/ibex_instr_writer_pkg.sv
// ibex_instr_writer_pkg
// Shared types for the instruction writer:
//   opcode_e        - RV32I / CUSTOM_0 major opcodes of the core's opcode map
//   instr_fmt_e     - encoding format selected by an opcode
//   writer_state_e  - drain FSM states
//   opcode_fmt()    - maps an opcode to its encoding format (FMT_NONE = not encodable)
package ibex_instr_writer_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD     = 7'h03,
    OPCODE_CUSTOM_0 = 7'h0b,
    OPCODE_MISC_MEM = 7'h0f,
    OPCODE_OP_IMM   = 7'h13,
    OPCODE_AUIPC    = 7'h17,
    OPCODE_STORE    = 7'h23,
    OPCODE_OP       = 7'h33,
    OPCODE_LUI      = 7'h37,
    OPCODE_BRANCH   = 7'h63,
    OPCODE_JALR     = 7'h67,
    OPCODE_JAL      = 7'h6f,
    OPCODE_SYSTEM   = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_U,
    FMT_NONE
  } instr_fmt_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_REQ,
    WR_WAIT
  } writer_state_e;

  // BRANCH and JAL use B/J immediates that this writer does not build, so
  // they fall into FMT_NONE together with unknown opcodes.
  function automatic instr_fmt_e opcode_fmt(input logic [6:0] op);
    instr_fmt_e fmt;
    case (op)
      OPCODE_OP, OPCODE_CUSTOM_0:                 fmt = FMT_R;
      OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR,
      OPCODE_SYSTEM, OPCODE_MISC_MEM:             fmt = FMT_I;
      OPCODE_STORE:                               fmt = FMT_S;
      OPCODE_LUI, OPCODE_AUIPC:                   fmt = FMT_U;
      default:                                    fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/ibex_instr_writer_if.sv
// ibex_instr_writer_if
// Ibex-style instruction-memory write port.
//   req/addr/we/be/wdata : driven by the writer (master)
//   gnt/rvalid/err       : driven by the memory (slave); err is qualified by rvalid
interface ibex_instr_writer_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, err);
endinterface

// File: rtl/ibex_instr_writer_fifo.sv
// ibex_instr_writer_fifo
// Synchronous FIFO of DEPTH x WIDTH holding encoded instruction words.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write an entry (honoured when not full, or when full with a pop)
//   pop_i/rdata_o : rdata_o shows the head; pop_i removes it
//   full_o, empty_o, count_o : occupancy status (count is clog2(DEPTH)+1 bits)
module ibex_instr_writer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is read directly so the drain FSM can capture it on the pop cycle.
  assign rdata_o = storage[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      storage[wr_ptr_reg] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end
endmodule

// File: rtl/ibex_instr_writer.sv
// ibex_instr_writer
// Encodes field-level instruction requests into 32-bit RV32I/CUSTOM_0 words,
// buffers them in a FIFO and writes them to instruction memory at sequential
// word addresses (wrapping inside a SIZE_WORDS window starting at BASE_ADDR).
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   start_i               : rewind write pointer to BASE_ADDR and clear err_o
//                           (deferred to the end of an in-flight write)
//   req_valid_i/ready_o   : request handshake; opcode_i, rd_i, rs1_i, rs2_i,
//                           funct3_i, funct7_i, imm_i carry the fields
//   mem                   : write port (ibex_instr_writer_if.master)
//   busy_o                : FIFO non-empty or write in flight
//   err_o                 : sticky; dropped request or memory error
//   words_written_o       : successful writes, saturating
// Build option: define IBEX_INSTR_WRITER_RANGE_CHECK_EN to reject immediates
// that do not fit the selected format instead of truncating them.
module ibex_instr_writer
  import ibex_instr_writer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  ibex_instr_writer_if.master mem,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] words_written_o
);
  localparam int          CNTW      = $clog2(DEPTH) + 1;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (SIZE_WORDS - 1));

  // ---------------- encoder ----------------
  instr_fmt_e  fmt;
  logic [31:0] enc_word;
  logic        range_ok;

  always_comb begin
    fmt      = opcode_fmt(opcode_i);
    enc_word = '0;
    case (fmt)
      FMT_R:   enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I:   enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S:   enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_U:   enc_word = {imm_i[31:12], rd_i, opcode_i};
      default: enc_word = '0;
    endcase
  end

`ifdef IBEX_INSTR_WRITER_RANGE_CHECK_EN
  // I/S immediates must be a sign-extended 12-bit value; U immediates must
  // have no low bits set.
  always_comb begin
    range_ok = 1'b1;
    if (fmt == FMT_I || fmt == FMT_S) begin
      range_ok = (imm_i[31:11] == {21{imm_i[11]}});
    end else if (fmt == FMT_U) begin
      range_ok = (imm_i[11:0] == 12'h000);
    end
  end
`else
  assign range_ok = 1'b1;
`endif

  // ---------------- FIFO ----------------
  logic            fifo_full, fifo_empty, pop, push, accept, drop_err;
  logic [31:0]     fifo_rdata;
  logic [CNTW-1:0] fifo_count;

  assign req_ready_o = !fifo_full;
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && (fmt != FMT_NONE) && range_ok;
  assign drop_err    = accept && !push;

  ibex_instr_writer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (enc_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------- drain FSM ----------------
  writer_state_e state_reg, state_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic          err_reg, err_next;
  logic          start_pend_reg, start_pend_next;
  logic [15:0]   count_reg, count_next;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    err_next        = err_reg;
    start_pend_next = start_pend_reg;
    count_next      = count_reg;
    pop             = 1'b0;

    case (state_reg)
      WR_IDLE: begin
        if (start_i) begin
          addr_next = BASE_ADDR;
          err_next  = 1'b0;
        end
        if (!fifo_empty) begin
          pop        = 1'b1;
          wdata_next = fifo_rdata;
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        // An issued request is never withdrawn; a rewind waits for completion.
        if (start_i) start_pend_next = 1'b1;
        if (mem.gnt) state_next = WR_WAIT;
      end
      WR_WAIT: begin
        if (start_i) start_pend_next = 1'b1;
        if (mem.rvalid) begin
          // A rewind arriving with (or before) the response beats the increment.
          if (start_i || start_pend_reg) begin
            addr_next       = BASE_ADDR;
            err_next        = 1'b0;
            start_pend_next = 1'b0;
          end else begin
            addr_next = (addr_reg == LAST_ADDR) ? BASE_ADDR : addr_reg + 32'd4;
          end
          if (mem.err) begin
            err_next = 1'b1;
          end else if (count_reg != 16'hFFFF) begin
            count_next = count_reg + 16'd1;
          end
          if (!fifo_empty) begin
            pop        = 1'b1;
            wdata_next = fifo_rdata;
            state_next = WR_REQ;
          end else begin
            state_next = WR_IDLE;
          end
        end
      end
      default: state_next = WR_IDLE;
    endcase

    if (drop_err) err_next = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= WR_IDLE;
      addr_reg       <= BASE_ADDR;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
      start_pend_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      err_reg        <= err_next;
      start_pend_reg <= start_pend_next;
      count_reg      <= count_next;
    end
  end

  assign mem.req         = (state_reg == WR_REQ);
  assign mem.addr        = addr_reg;
  assign mem.wdata       = wdata_reg;
  assign mem.we          = 1'b1;
  assign mem.be          = 4'hF;
  assign busy_o          = (fifo_count != '0) || (state_reg != WR_IDLE);
  assign err_o           = err_reg;
  assign words_written_o = count_reg;
endmodule

// File: tb/tb_ibex_instr_writer.sv
// tb_ibex_instr_writer
// Directed scenarios followed by randomized traffic; every cycle the DUT is
// compared against a transaction-level model (queue of encoded words, word
// index into the address window, error flag, write count).
module tb_ibex_instr_writer;
  localparam int          DEPTH      = 4;
  localparam logic [31:0] BASE       = 32'h0000_1000;
  localparam int          SIZE_WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, req_valid = 1'b0, req_ready;
  logic [6:0]  opcode = '0, f7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] imm = '0;
  logic        busy, err;
  logic [15:0] ww;

  ibex_instr_writer_if mem_if();

  ibex_instr_writer #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .SIZE_WORDS(SIZE_WORDS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(f3), .funct7_i(f7), .imm_i(imm), .mem(mem_if.slave),
    .busy_o(busy), .err_o(err), .words_written_o(ww)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  // model state
  logic [31:0] m_q[$];
  bit          m_active, m_granted, m_start_pend, m_err;
  int          m_idx, m_ww;
  logic [31:0] m_data;

  // stimulus knobs
  bit          rand_mode, start_flag, force_merr, last_accept;
  int          gnt_hold, rv_hold;
  logic        d_valid = 1'b0;
  logic [6:0]  d_op, d_f7;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [2:0]  d_f3;
  logic [31:0] d_imm;
  logic [31:0] wlog_addr[$], wlog_data[$];
  logic [6:0]  ops [14] = '{7'h33, 7'h0b, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0f,
                            7'h23, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h7f, 7'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Field packing by arithmetic placement of each field at its bit offset.
  function automatic void encode(input logic [6:0] op, input logic [4:0] a_rd, a_rs1, a_rs2,
                                 input logic [2:0] a_f3, input logic [6:0] a_f7,
                                 input logic [31:0] a_imm, output logic [31:0] w, output bit ok);
    logic [31:0] o, d, s1, s2, x3, x7;
    o = 32'(op); d = 32'(a_rd); s1 = 32'(a_rs1); s2 = 32'(a_rs2); x3 = 32'(a_f3); x7 = 32'(a_f7);
    ok = 1'b1;
    w  = '0;
    case (op)
      7'h33, 7'h0b: w = (x7 << 25) | (s2 << 20) | (s1 << 15) | (x3 << 12) | (d << 7) | o;
      7'h03, 7'h0f, 7'h13, 7'h67, 7'h73, 7'h23: begin
        if (op == 7'h23)
          w = (((a_imm >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (x3 << 12)
              | ((a_imm & 32'h1F) << 7) | o;
        else
          w = ((a_imm & 32'hFFF) << 20) | (s1 << 15) | (x3 << 12) | (d << 7) | o;
`ifdef IBEX_INSTR_WRITER_RANGE_CHECK_EN
        ok = ($signed(a_imm) >= -2048) && ($signed(a_imm) <= 2047);
`endif
      end
      7'h37, 7'h17: begin
        w = (a_imm & 32'hFFFFF000) | (d << 7) | o;
`ifdef IBEX_INSTR_WRITER_RANGE_CHECK_EN
        ok = (a_imm % 4096) == 0;
`endif
      end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic compare_all();
    chk("ready",   32'(req_ready),   32'(m_q.size() < DEPTH));
    chk("mem_req", 32'(mem_if.req),  32'(m_active && !m_granted));
    chk("busy",    32'(busy),        32'(m_q.size() != 0 || m_active));
    chk("err",     32'(err),         32'(m_err));
    chk("words",   32'(ww),          32'(m_ww));
    chk("addr",    mem_if.addr,      BASE + 32'(4 * m_idx));
    chk("we_be",   32'({mem_if.we, mem_if.be}), 32'h1F);
    if (m_active && !m_granted) chk("wdata", mem_if.wdata, m_data);
  endtask

  // One clock: compare, drive next inputs, advance the model to the next edge.
  task automatic step();
    logic [31:0] w;
    bit          ok, acc;
    @(negedge clk);
    compare_all();
    if (rand_mode) begin
      req_valid = ($urandom % 2) == 0;
      opcode    = ops[$urandom % 14];
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom);
      imm = $urandom;
      case ($urandom % 3)
        1: imm = {{20{imm[11]}}, imm[11:0]};
        2: imm[11:0] = 12'h000;
        default: ;
      endcase
      start = ($urandom % 40) == 0;
    end else begin
      req_valid = d_valid; opcode = d_op; rd = d_rd; rs1 = d_rs1; rs2 = d_rs2;
      f3 = d_f3; f7 = d_f7; imm = d_imm;
      start = start_flag;
      start_flag = 1'b0;
    end
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.err = 1'b0;
    if (gnt_hold > 0) gnt_hold--;
    else if (rand_mode) mem_if.gnt = ($urandom % 3) == 0;
    else mem_if.gnt = m_active && !m_granted;
    if (m_active && m_granted) begin
      if (rv_hold > 0) rv_hold--;
      else begin
        mem_if.rvalid = rand_mode ? (($urandom % 3) == 0) : 1'b1;
        mem_if.err    = rand_mode ? (($urandom % 6) == 0) : force_merr;
      end
    end
    if (mem_if.req && mem_if.gnt) begin
      wlog_addr.push_back(mem_if.addr);
      wlog_data.push_back(mem_if.wdata);
    end

    // model advance
    acc = req_valid && (m_q.size() < DEPTH);
    last_accept = acc;
    w = '0; ok = 1'b0;
    if (acc) encode(opcode, rd, rs1, rs2, f3, f7, imm, w, ok);
    if (!m_active) begin
      if (start) begin m_idx = 0; m_err = 1'b0; end
    end else begin
      if (start) m_start_pend = 1'b1;
      if (!m_granted) begin
        if (mem_if.gnt) m_granted = 1'b1;
      end else if (mem_if.rvalid) begin
        if (m_start_pend) begin m_idx = 0; m_err = 1'b0; m_start_pend = 1'b0; end
        else m_idx = (m_idx + 1) % SIZE_WORDS;
        if (mem_if.err) m_err = 1'b1;
        else if (m_ww < 65535) m_ww++;
        m_active = 1'b0;
      end
    end
    if (!m_active && m_q.size() != 0) begin
      m_data = m_q.pop_front();
      m_active = 1'b1;
      m_granted = 1'b0;
    end
    if (acc) begin
      if (ok) m_q.push_back(w);
      else m_err = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] a_rd, a_rs1, a_rs2,
                      input logic [2:0] a_f3, input logic [6:0] a_f7, input logic [31:0] a_imm);
    int guard;
    d_op = op; d_rd = a_rd; d_rs1 = a_rs1; d_rs2 = a_rs2; d_f3 = a_f3; d_f7 = a_f7; d_imm = a_imm;
    d_valid = 1'b1;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!last_accept && guard < 60);
    d_valid = 1'b0;
    if (!last_accept) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: got no accept within 60 cycles, expected accept");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bit ok;
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.err = 1'b0;
    m_idx = 0; m_ww = 0; m_err = 0; m_active = 0; m_granted = 0; m_start_pend = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req",   32'(mem_if.req), 32'd0);
    chk("rst_addr",  mem_if.addr,     BASE);
    chk("rst_wdata", mem_if.wdata,    32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_err",   32'(err),        32'd0);
    chk("rst_words", 32'(ww),         32'd0);
    chk("rst_ready", 32'(req_ready),  32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2 with immediate gnt/rvalid
    encode(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, w, ok);
    chk("model_add", w, 32'h002081B3);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    idle(6);
    chk("add_addr",  wlog_addr[0], BASE);
    chk("add_data",  wlog_data[0], 32'h002081B3);
    chk("add_words", 32'(ww), 32'd1);

    // rewind in idle, four formats, then a fifth word that wraps
    start_flag = 1'b1; idle(1);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    send(7'h0b, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    idle(8);
    chk("fmt_i", wlog_data[1], 32'h00500093); chk("fmt_i_a", wlog_addr[1], BASE);
    chk("fmt_s", wlog_data[2], 32'h0020A423); chk("fmt_s_a", wlog_addr[2], BASE + 32'h4);
    chk("fmt_u", wlog_data[3], 32'h123452B7); chk("fmt_u_a", wlog_addr[3], BASE + 32'h8);
    chk("fmt_r", wlog_data[4], 32'h0031008B); chk("fmt_r_a", wlog_addr[4], BASE + 32'hC);
    chk("wrap_a", wlog_addr[5], BASE);

    // backpressure: grant withheld while six requests arrive
    gnt_hold = 10;
    for (int k = 1; k <= 5; k++) send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
    idle(1);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_req",   32'(mem_if.req), 32'd1);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    idle(30);
    for (int k = 0; k < 6; k++) begin
      chk("bp_data", wlog_data[6 + k], (32'(k + 1) << 20) | 32'h93);
      chk("bp_addr", wlog_addr[6 + k], BASE + 32'(4 * ((1 + k) % 4)));
    end

    // dropped BRANCH
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16);
    idle(3);
    chk("br_err",   32'(err), 32'd1);
    chk("br_log",   32'(wlog_addr.size()), 32'd12);
    chk("br_words", 32'(ww), 32'd12);

    // rewind arriving while the write waits for its response
    rv_hold = 6;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    idle(3);
    start_flag = 1'b1;
    idle(10);
    chk("sw_err",  32'(err), 32'd0);
    chk("sw_addr", wlog_addr[12], BASE + 32'hC);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    idle(6);
    chk("sw_next", wlog_addr[13], BASE);

    // memory error response
    force_merr = 1'b1;
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    idle(6);
    force_merr = 1'b0;
    chk("merr_err",   32'(err), 32'd1);
    chk("merr_words", 32'(ww), 32'd14);
    chk("merr_addr",  mem_if.addr, BASE + 32'h8);
    start_flag = 1'b1; idle(2);

    // out-of-range I immediate
    encode(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, w, ok);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    idle(6);
`ifdef IBEX_INSTR_WRITER_RANGE_CHECK_EN
    chk("rng_model", 32'(ok), 32'd0);
    chk("rng_err",   32'(err), 32'd1);
    chk("rng_log",   32'(wlog_addr.size()), 32'd15);
`else
    chk("rng_model", w, 32'h80000093);
    chk("rng_err",   32'(err), 32'd0);
    chk("rng_data",  wlog_data[15], 32'h80000093);
`endif
    start_flag = 1'b1; idle(2);

    // randomized traffic
    rand_mode = 1'b1;
    idle(3000);
    rand_mode = 1'b0;
    d_valid = 1'b0;
    idle(40);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
